// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, unit select codes and FSM encoding for the ALU dispatcher
package alu_pkg;

  localparam int A_WIDTH_DEF = 16;
  localparam int B_WIDTH_DEF = 16;
  localparam int OUT_WIDTH   = A_WIDTH_DEF + B_WIDTH_DEF;

  localparam logic [1:0] UNIT_ARITH = 2'b00;
  localparam logic [1:0] UNIT_LOGIC = 2'b01;
  localparam logic [1:0] UNIT_CMP   = 2'b10;
  localparam logic [1:0] UNIT_SHIFT = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/alu_rsp_mux.sv
// rtl/alu_rsp_mux.sv - combinational 4:1 select of unit result and flag by unit select
module alu_rsp_mux
  import alu_pkg::*;
#(
  parameter int OUT_W = OUT_WIDTH
) (
  input  logic [1:0]       unit_sel_i,
  input  logic [OUT_W-1:0] arith_out_i,
  input  logic [OUT_W-1:0] logic_out_i,
  input  logic [OUT_W-1:0] cmp_out_i,
  input  logic [OUT_W-1:0] shift_out_i,
  input  logic             arith_flag_i,
  input  logic             logic_flag_i,
  input  logic             cmp_flag_i,
  input  logic             shift_flag_i,
  output logic [OUT_W-1:0] out_o,
  output logic             flag_o
);

  always_comb begin
    out_o  = '0;
    flag_o = 1'b0;
    case (unit_sel_i)
      UNIT_ARITH: begin out_o = arith_out_i; flag_o = arith_flag_i; end
      UNIT_LOGIC: begin out_o = logic_out_i; flag_o = logic_flag_i; end
      UNIT_CMP:   begin out_o = cmp_out_i;   flag_o = cmp_flag_i;   end
      UNIT_SHIFT: begin out_o = shift_out_i; flag_o = shift_flag_i; end
      default:    begin out_o = '0;          flag_o = 1'b0;         end
    endcase
  end

endmodule

// File: rtl/alu_op_dispatcher.sv
// rtl/alu_op_dispatcher.sv - command-side initiator: latch operands, pulse one unit enable, await its flag, return result or timeout
module alu_op_dispatcher
  import alu_pkg::*;
#(
  parameter int A_WIDTH = A_WIDTH_DEF,
  parameter int B_WIDTH = B_WIDTH_DEF,
  parameter int TIMEOUT = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [3:0]                 cmd_func,
  input  logic [A_WIDTH-1:0]         cmd_a,
  input  logic [B_WIDTH-1:0]         cmd_b,
  output logic [A_WIDTH-1:0]         ALU_A,
  output logic [B_WIDTH-1:0]         ALU_B,
  output logic [1:0]                 ALU_FUNC,
  output logic                       Arith_Enable,
  output logic                       Logic_Enable,
  output logic                       CMP_Enable,
  output logic                       SHIFT_Enable,
  input  logic [A_WIDTH+B_WIDTH-1:0] Arith_OUT,
  input  logic [A_WIDTH+B_WIDTH-1:0] Logic_OUT,
  input  logic [A_WIDTH+B_WIDTH-1:0] CMP_OUT,
  input  logic [A_WIDTH+B_WIDTH-1:0] SHIFT_OUT,
  input  logic                       Arith_Flag,
  input  logic                       Logic_Flag,
  input  logic                       CMP_Flag,
  input  logic                       SHIFT_Flag,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [A_WIDTH+B_WIDTH-1:0] rsp_data,
  output logic                       rsp_err
);

  localparam int OUT_W = A_WIDTH + B_WIDTH;
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [A_WIDTH-1:0] alu_a_q, alu_a_d;
  logic [B_WIDTH-1:0] alu_b_q, alu_b_d;
  logic [1:0]         alu_func_q, alu_func_d;
  logic [1:0]         unit_sel_q, unit_sel_d;
  logic [7:0]         timer_q, timer_d;
  logic [OUT_W-1:0]   rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;
  logic [OUT_W-1:0]   sel_out;
  logic               sel_flag;

  alu_rsp_mux #(.OUT_W(OUT_W)) u_rsp_mux (
    .unit_sel_i   (unit_sel_q),
    .arith_out_i  (Arith_OUT),
    .logic_out_i  (Logic_OUT),
    .cmp_out_i    (CMP_OUT),
    .shift_out_i  (SHIFT_OUT),
    .arith_flag_i (Arith_Flag),
    .logic_flag_i (Logic_Flag),
    .cmp_flag_i   (CMP_Flag),
    .shift_flag_i (SHIFT_Flag),
    .out_o        (sel_out),
    .flag_o       (sel_flag)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_func_q <= '0;
      unit_sel_q <= '0;
      timer_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_func_q <= alu_func_d;
      unit_sel_q <= unit_sel_d;
      timer_q    <= timer_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_func_d = alu_func_q;
    unit_sel_d = unit_sel_q;
    timer_d    = timer_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          alu_a_d    = cmd_a;
          alu_b_d    = cmd_b;
          alu_func_d = cmd_func[1:0];
          unit_sel_d = cmd_func[3:2];
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A flag on the expiry cycle wins over the timeout.
        if (sel_flag) begin
          rsp_data_d = sel_out;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end else if (timer_q == TIMER_LAST) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready    = (state_q == IDLE) && !rst;
  assign Arith_Enable = (state_q == ISSUE) && (unit_sel_q == UNIT_ARITH);
  assign Logic_Enable = (state_q == ISSUE) && (unit_sel_q == UNIT_LOGIC);
  assign CMP_Enable   = (state_q == ISSUE) && (unit_sel_q == UNIT_CMP);
  assign SHIFT_Enable = (state_q == ISSUE) && (unit_sel_q == UNIT_SHIFT);
  assign ALU_A        = alu_a_q;
  assign ALU_B        = alu_b_q;
  assign ALU_FUNC     = alu_func_q;
  assign rsp_valid    = (state_q == RESP);
  assign rsp_data     = rsp_data_q;
  assign rsp_err      = rsp_err_q;

endmodule

// File: tb/tb_alu_op_dispatcher.sv
// tb/tb_alu_op_dispatcher.sv - scoreboard bench for alu_op_dispatcher with behavioural unit models
`timescale 1ns/1ps
module tb_alu_op_dispatcher;
  import alu_pkg::*;

  localparam int AW = 16;
  localparam int BW = 16;
  localparam int OW = AW + BW;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid, cmd_ready;
  logic [3:0]    cmd_func;
  logic [AW-1:0] cmd_a, ALU_A;
  logic [BW-1:0] cmd_b, ALU_B;
  logic [1:0]    ALU_FUNC;
  logic          Arith_Enable, Logic_Enable, CMP_Enable, SHIFT_Enable;
  logic [OW-1:0] Arith_OUT = '0, Logic_OUT = '0, CMP_OUT = '0, SHIFT_OUT = '0;
  logic          Arith_Flag = 1'b0, Logic_Flag = 1'b0, CMP_Flag = 1'b0, SHIFT_Flag = 1'b0;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [OW-1:0] rsp_data;

  alu_op_dispatcher #(.A_WIDTH(AW), .B_WIDTH(BW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_func(cmd_func),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUNC(ALU_FUNC),
    .Arith_Enable(Arith_Enable), .Logic_Enable(Logic_Enable),
    .CMP_Enable(CMP_Enable), .SHIFT_Enable(SHIFT_Enable),
    .Arith_OUT(Arith_OUT), .Logic_OUT(Logic_OUT), .CMP_OUT(CMP_OUT), .SHIFT_OUT(SHIFT_OUT),
    .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag), .CMP_Flag(CMP_Flag), .SHIFT_Flag(SHIFT_Flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] data;
    logic          err;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   arith_cnt = 0, logic_cnt = 0, cmp_cnt = 0, shift_cnt = 0;
  logic arith_mute = 1'b0;
  logic logic_spur = 1'b0;
  int   cmp_delay = 0;
  int   cmp_pend = 0;
  int   ready_wait = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [OW-1:0] unit_calc(input logic [3:0] f, input logic [AW-1:0] a,
                                              input logic [BW-1:0] b);
    logic [OW-1:0] r;
    r = '0;
    case (f[3:2])
      2'b00: case (f[1:0])
        2'd0:    r = OW'(a) + OW'(b);
        2'd1:    r = OW'(a) - OW'(b);
        2'd2:    r = OW'(a) * OW'(b);
        default: r = {a, b};
      endcase
      2'b01: case (f[1:0])
        2'd0:    r = OW'(a & b);
        2'd1:    r = OW'(a | b);
        2'd2:    r = OW'(a ^ b);
        default: r = OW'(~(a & b));
      endcase
      2'b10: case (f[1:0])
        2'd1:    r = (a == b) ? OW'(1) : '0;
        2'd2:    r = (a > b)  ? OW'(2) : '0;
        2'd3:    r = (a < b)  ? OW'(3) : '0;
        default: r = '0;
      endcase
      default: case (f[1:0])
        2'd0:    r = OW'(a) << b[3:0];
        2'd1:    r = OW'(a >> b[3:0]);
        2'd2:    r = {b, a};
        default: r = OW'(a);
      endcase
    endcase
    return r;
  endfunction

  // Unit models: results track the operand bus every cycle, flags are registered off the enable.
  always @(posedge clk) begin
    Arith_OUT  <= unit_calc({UNIT_ARITH, ALU_FUNC}, ALU_A, ALU_B);
    Arith_Flag <= Arith_Enable && !arith_mute;
    Logic_OUT  <= logic_spur ? OW'(32'hDEAD) : unit_calc({UNIT_LOGIC, ALU_FUNC}, ALU_A, ALU_B);
    Logic_Flag <= Logic_Enable || logic_spur;
    CMP_OUT    <= unit_calc({UNIT_CMP, ALU_FUNC}, ALU_A, ALU_B);
    cmp_pend   <= CMP_Enable ? cmp_delay : ((cmp_pend != 0) ? cmp_pend - 1 : 0);
    CMP_Flag   <= (CMP_Enable && cmp_delay == 0) || (cmp_pend == 1);
    SHIFT_OUT  <= unit_calc({UNIT_SHIFT, ALU_FUNC}, ALU_A, ALU_B);
    SHIFT_Flag <= SHIFT_Enable;
  end

  always @(negedge clk) begin
    if (Arith_Enable) arith_cnt++;
    if (Logic_Enable) logic_cnt++;
    if (CMP_Enable)   cmp_cnt++;
    if (SHIFT_Enable) shift_cnt++;
  end

  always @(negedge clk) begin : monitor
    exp_t m;
    if (!rst && rsp_valid && rsp_ready) begin
      check("sb_nonempty", (sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        m = sb_q.pop_front();
        check("rsp_data", rsp_data, m.data);
        check("rsp_err", rsp_err, m.err);
      end
    end
  end

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 rsp_ready = v;
    @(negedge clk);
  endtask

  task automatic run_op(input logic [3:0] f, input logic [AW-1:0] a, input logic [BW-1:0] b,
                        input logic exp_err, input int exp_lat, input int spur_k);
    exp_t e;
    int   k;
    ready_wait = 0;
    while (cmd_ready !== 1'b1 && ready_wait < 100) begin
      @(negedge clk);
      ready_wait++;
    end
    check("cmd_ready_wait", cmd_ready, 1);
    if (cmd_ready !== 1'b1) return;
    cmd_valid = 1'b1;
    cmd_func  = f;
    cmd_a     = a;
    cmd_b     = b;
    e.err  = exp_err;
    e.data = exp_err ? '0 : unit_calc(f, a, b);
    sb_q.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("issue_en", {Arith_Enable, Logic_Enable, CMP_Enable, SHIFT_Enable}, 4'b1000 >> f[3:2]);
    check("issue_func", ALU_FUNC, f[1:0]);
    check("issue_ops", {ALU_A, ALU_B}, {a, b});
    k = 1;
    while (rsp_valid !== 1'b1 && k < 60) begin
      logic_spur = (k == spur_k);
      @(negedge clk);
      k++;
      if (k == 2) begin
        check("wait_en", {Arith_Enable, Logic_Enable, CMP_Enable, SHIFT_Enable}, 0);
        check("wait_ready", cmd_ready, 0);
      end
    end
    logic_spur = 1'b0;
    check("rsp_latency", k, exp_lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]    rf;
    logic [AW-1:0] ra;
    logic [BW-1:0] rb;
    logic [OW-1:0] bp_exp;
    int            c0;
    logic          seen_valid;

    cmd_valid = 1'b0;
    cmd_func  = '0;
    cmd_a     = '0;
    cmd_b     = '0;
    rsp_ready = 1'b1;
    rst       = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_en", {Arith_Enable, Logic_Enable, CMP_Enable, SHIFT_Enable}, 0);
    check("rst_bus", {ALU_A, ALU_B, ALU_FUNC}, 0);
    check("rst_rsp", {rsp_data, rsp_err}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", cmd_ready, 1);

    run_op(4'b1001, 16'd5, 16'd5, 1'b0, 3, 0);
    run_op(4'b1010, 16'd9, 16'd3, 1'b0, 3, 0);
    run_op(4'b1011, 16'd3, 16'd9, 1'b0, 3, 0);
    check("b2b_ready_wait", ready_wait, 1);

    for (int i = 0; i < 8; i++) begin
      rf = 4'($urandom_range(0, 15));
      ra = AW'($urandom);
      rb = BW'($urandom);
      run_op(rf, ra, rb, 1'b0, 3, 0);
    end

    arith_mute = 1'b1;
    c0 = arith_cnt;
    run_op(4'b0000, 16'd7, 16'd8, 1'b1, TO + 2, 0);
    repeat (2) @(negedge clk);
    check("timeout_pulses", arith_cnt - c0, 1);
    arith_mute = 1'b0;

    cmp_delay = TO - 1;
    run_op(4'b1001, 16'd4, 16'd4, 1'b0, TO + 2, 0);
    cmp_delay = TO;
    run_op(4'b1010, 16'd9, 16'd1, 1'b1, TO + 2, 0);
    repeat (3) @(negedge clk);

    cmp_delay = 3;
    run_op(4'b1011, 16'd2, 16'd6, 1'b0, 6, 2);
    cmp_delay = 0;

    set_ready(1'b0);
    c0 = logic_cnt;
    bp_exp = unit_calc(4'b0110, 16'h00ff, 16'h0f0f);
    run_op(4'b0110, 16'h00ff, 16'h0f0f, 1'b0, 3, 0);
    cmd_valid = 1'b1;
    cmd_func  = 4'b0101;
    cmd_a     = 16'd1;
    cmd_b     = 16'd2;
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", rsp_valid, 1);
      check("bp_data", rsp_data, bp_exp);
      check("bp_err", rsp_err, 0);
      check("bp_cmd_ready", cmd_ready, 0);
    end
    cmd_valid = 1'b0;
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("bp_no_accept", logic_cnt - c0, 1);
    check("bp_idle_ready", cmd_ready, 1);

    cmp_delay = 6;
    c0 = cmp_cnt;
    cmd_valid = 1'b1;
    cmd_func  = 4'b1001;
    cmd_a     = 16'd7;
    cmd_b     = 16'd7;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_bus", {ALU_A, ALU_B, ALU_FUNC}, 0);
    check("mid_rst_en", {Arith_Enable, Logic_Enable, CMP_Enable, SHIFT_Enable}, 0);
    check("mid_rst_rsp", {rsp_valid, rsp_data, rsp_err}, 0);
    check("mid_rst_ready", cmd_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen_valid = seen_valid | rsp_valid;
    end
    check("post_rst_no_rsp", seen_valid, 0);
    check("post_rst_ready", cmd_ready, 1);
    check("post_rst_pulses", cmp_cnt - c0, 1);
    cmp_delay = 0;
    run_op(4'b1001, 16'd7, 16'd7, 1'b0, 3, 0);

    repeat (3) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_op_dispatcher.md
Name: alu_op_dispatcher

Overview:
Command-side initiator for the ALU unit bus. It accepts one operation per valid/ready handshake and latches the operands. It then pulses the enable of the selected unit (arithmetic, logic, compare or shift) for one cycle and waits for that unit's registered flag. It captures the unit's result and returns it on a valid/ready response channel, with a timeout error if the unit never answers.

Parameters:
A_WIDTH, 16, width of operand A
B_WIDTH, 16, width of operand B
TIMEOUT, 8, maximum WAIT cycles before error; legal range 2..255

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  dispatcher can accept a command
cmd_func  in  4  [3:2] unit select, [1:0] unit function
cmd_a  in  A_WIDTH  operand A
cmd_b  in  B_WIDTH  operand B
ALU_A  out  A_WIDTH  operand A to units
ALU_B  out  B_WIDTH  operand B to units
ALU_FUNC  out  2  function code to units
Arith_Enable, Logic_Enable, CMP_Enable, SHIFT_Enable  out  1 each  unit enables
Arith_OUT, Logic_OUT, CMP_OUT, SHIFT_OUT  in  A_WIDTH+B_WIDTH each  unit results
Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag  in  1 each  unit result-valid flags
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_data  out  A_WIDTH+B_WIDTH  captured result
rsp_err  out  1  1 = timeout, rsp_data is 0

Behaviour:
- Reset (rst high, asynchronous):
  - state goes to IDLE.
  - ALU_A, ALU_B, ALU_FUNC, all enables, rsp_valid, rsp_data, rsp_err and the timer are cleared to 0.
  - cmd_ready = 0 while rst is high.
  - Reset mid-operation drops the pending command or response; no enable pulse follows reset.
- Unit select codes: 00 arith, 01 logic, 10 cmp, 11 shift.
- FSM states:
  - IDLE:
    - cmd_ready = 1.
    - On cmd_valid, latch cmd_a into ALU_A, cmd_b into ALU_B, cmd_func[1:0] into ALU_FUNC, and cmd_func[3:2] into the unit select; go to ISSUE.
  - ISSUE:
    - Exactly one enable (the selected unit's) is high for this one cycle; all others stay 0.
    - Clear the timer; go to WAIT.
  - WAIT:
    - All enables are 0.
    - If the selected unit's flag = 1: rsp_data <= that unit's OUT, rsp_err <= 0, go to RESP.
    - Else if timer == TIMEOUT-1: rsp_data <= 0, rsp_err <= 1, go to RESP.
    - Else timer++.
    - Flags from non-selected units are ignored in every state.
  - RESP:
    - rsp_valid = 1; rsp_data and rsp_err are held stable until rsp_valid && rsp_ready.
    - On that handshake, clear rsp_valid and go to IDLE.
- cmd_ready = 0 in ISSUE, WAIT and RESP; cmd_valid is ignored there.
- ALU_A, ALU_B and ALU_FUNC hold their latched values until the next accepted command.
- Latency:
  - Handshake at cycle T, enable high in T+1, unit flag high in T+2, rsp_valid high from T+3.
  - Minimum of 4 cycles per operation, since a command is accepted only in IDLE.
  - Timeout path: WAIT lasts exactly TIMEOUT cycles, so rsp_valid rises at T+2+TIMEOUT.
- A flag arriving on the same cycle the timer expires takes priority: the result is captured with rsp_err = 0.
- The result is passed through unmodified at A_WIDTH+B_WIDTH bits; no arithmetic is performed in the dispatcher.

Decomposition:
- Shared package alu_pkg:
  - unit select localparams UNIT_ARITH, UNIT_LOGIC, UNIT_CMP, UNIT_SHIFT.
  - FSM state encoding IDLE, ISSUE, WAIT, RESP.
  - OUT_WIDTH = A_WIDTH+B_WIDTH.
- One natural sub-module: alu_rsp_mux, a combinational 4:1 select of {OUT, Flag} by unit select.
- The FSM, timer and response register stay in alu_op_dispatcher.

Test Plan:
- CMP equal: cmd_func=4'b1001, A=5, B=5, compare-unit model attached.
  - CMP_Enable is high only in T+1, ALU_FUNC=01.
  - rsp_valid rises at T+3 with rsp_data=1, rsp_err=0.
- CMP greater then less, back to back:
  - A=9, B=3, func 1010 gives rsp_data=2.
  - Then A=3, B=9, func 1011 gives rsp_data=3.
  - The second cmd_ready rises only after the first response handshake.
- Timeout: func=4'b0000, arith model never raises its flag, TIMEOUT=8.
  - rsp_valid at T+10, rsp_err=1, rsp_data=0.
  - Arith_Enable pulsed exactly once.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid.
  - rsp_data and rsp_err stay stable; cmd_ready stays 0.
  - A cmd_valid offered meanwhile is not accepted.
- Spurious flags: select the cmp unit, and pulse Logic_Flag with Logic_OUT=0xDEAD during WAIT.
  - Ignored; the response carries the CMP_OUT value.
- Reset mid-WAIT: assert rst two cycles into WAIT.
  - All outputs go to 0 immediately; no rsp_valid.
  - After release, IDLE with cmd_ready=1 and a new command completes normally.
